// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data port, resolves taken branches,
// stalls upstream while an access is in flight, and drives the MEM/WB register.
// Optional feature macro: MEM_SUBWORD_EN (byte/half/word accesses with lane steering).
module memory_access_stage #(
  parameter int DMEM_ADDR_W    = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_exmem_instruction,
  input  logic [63:0]            i_exmem_pc,
  input  logic [63:0]            i_exmem_rs2_value,
  input  logic [63:0]            i_exmem_alu_result,
  input  logic                   i_exmem_alu_zero,
  input  logic [63:0]            i_exmem_jmp_addr,
  input  logic                   i_exmem_branch,
  input  logic                   i_exmem_mem_write,
  input  logic                   i_exmem_mem_read,
  input  logic                   i_exmem_mem_to_reg,
  input  logic                   i_exmem_reg_write,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [DMEM_ADDR_W-1:0] o_dmem_addr,
  output logic [63:0]            o_dmem_wdata,
  output logic [7:0]             o_dmem_be,
  input  logic                   i_dmem_ack,
  input  logic [63:0]            i_dmem_rdata,
  output logic                   o_stall,
  output logic                   o_pc_src,
  output logic [63:0]            o_pc_target,
  output logic                   o_bus_error,
  output logic [31:0]            o_memwb_instruction,
  output logic [63:0]            o_memwb_pc,
  output logic [63:0]            o_memwb_alu_result,
  output logic [63:0]            o_memwb_read_data,
  output logic                   o_memwb_mem_to_reg,
  output logic                   o_memwb_reg_write
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [15:0] timeout_cnt;

  logic [31:0] cap_instruction;
  logic [63:0] cap_pc;
  logic [63:0] cap_alu_result;
  logic        cap_mem_to_reg;
  logic        cap_reg_write;
  logic        cap_is_load;

  logic                   mem_op;
  logic                   branch_taken;
  logic                   timeout_hit;
  logic                   misaligned;
  logic [7:0]             be_next;
  logic [63:0]            wdata_next;
  logic [63:0]            load_data;
  logic [DMEM_ADDR_W-1:0] addr_next;

  // A branch never becomes a memory access even if stray mem controls accompany it.
  assign mem_op       = (i_exmem_mem_read | i_exmem_mem_write) & ~i_exmem_branch;
  assign branch_taken = i_exmem_branch & i_exmem_alu_zero;
  assign timeout_hit  = (timeout_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign addr_next    = {i_exmem_alu_result[DMEM_ADDR_W-1:3], 3'b000};

`ifdef MEM_SUBWORD_EN
  logic [2:0]  req_offset;
  logic [2:0]  cap_funct3;
  logic [2:0]  cap_offset;
  logic [63:0] lane_rdata;
  logic        size_misaligned;

  assign req_offset = i_exmem_alu_result[2:0];
  assign wdata_next = i_exmem_rs2_value << {req_offset, 3'b000};
  assign misaligned = mem_op & size_misaligned;

  always_comb begin
    be_next         = 8'hFF;
    size_misaligned = 1'b0;
    case (i_exmem_instruction[13:12])
      2'b00: be_next = 8'h01 << req_offset;
      2'b01: begin
        be_next         = 8'h03 << req_offset;
        size_misaligned = req_offset[0];
      end
      2'b10: begin
        be_next         = 8'h0F << req_offset;
        size_misaligned = |req_offset[1:0];
      end
      default: begin
        be_next         = 8'hFF;
        size_misaligned = |req_offset;
      end
    endcase
  end

  // Pull the addressed lane down to bit 0, then extend according to the load kind.
  always_comb begin
    lane_rdata = i_dmem_rdata >> {cap_offset, 3'b000};
    case (cap_funct3)
      3'b000:  load_data = {{56{lane_rdata[7]}},  lane_rdata[7:0]};
      3'b001:  load_data = {{48{lane_rdata[15]}}, lane_rdata[15:0]};
      3'b010:  load_data = {{32{lane_rdata[31]}}, lane_rdata[31:0]};
      3'b100:  load_data = {56'd0, lane_rdata[7:0]};
      3'b101:  load_data = {48'd0, lane_rdata[15:0]};
      3'b110:  load_data = {32'd0, lane_rdata[31:0]};
      default: load_data = lane_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_funct3 <= 3'd0;
      cap_offset <= 3'd0;
    end else if (state == IDLE && mem_op) begin
      cap_funct3 <= i_exmem_instruction[14:12];
      cap_offset <= req_offset;
    end
  end
`else
  assign be_next    = 8'hFF;
  assign wdata_next = i_exmem_rs2_value;
  assign misaligned = 1'b0;
  assign load_data  = i_dmem_rdata;
`endif

  // Main sequencer: IDLE samples the EX/MEM bundle every edge; ACCESS waits for ack or timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      timeout_cnt         <= 16'd0;
      cap_instruction     <= '0;
      cap_pc              <= '0;
      cap_alu_result      <= '0;
      cap_mem_to_reg      <= 1'b0;
      cap_reg_write       <= 1'b0;
      cap_is_load         <= 1'b0;
      o_dmem_req          <= 1'b0;
      o_dmem_we           <= 1'b0;
      o_dmem_addr         <= '0;
      o_dmem_wdata        <= '0;
      o_dmem_be           <= '0;
      o_stall             <= 1'b0;
      o_pc_src            <= 1'b0;
      o_pc_target         <= '0;
      o_bus_error         <= 1'b0;
      o_memwb_instruction <= '0;
      o_memwb_pc          <= '0;
      o_memwb_alu_result  <= '0;
      o_memwb_read_data   <= '0;
      o_memwb_mem_to_reg  <= 1'b0;
      o_memwb_reg_write   <= 1'b0;
    end else begin
      o_pc_src    <= 1'b0;
      o_bus_error <= 1'b0;
      case (state)
        IDLE: begin
          o_pc_src    <= branch_taken;
          o_pc_target <= branch_taken ? i_exmem_jmp_addr : 64'd0;
          if (mem_op && !misaligned) begin
            state           <= ACCESS;
            timeout_cnt     <= 16'd0;
            o_stall         <= 1'b1;
            o_dmem_req      <= 1'b1;
            o_dmem_we       <= i_exmem_mem_write;
            o_dmem_addr     <= addr_next;
            o_dmem_wdata    <= wdata_next;
            o_dmem_be       <= be_next;
            cap_instruction <= i_exmem_instruction;
            cap_pc          <= i_exmem_pc;
            cap_alu_result  <= i_exmem_alu_result;
            cap_mem_to_reg  <= i_exmem_mem_to_reg;
            cap_reg_write   <= i_exmem_reg_write;
            cap_is_load     <= i_exmem_mem_read & ~i_exmem_mem_write;
          end else begin
            o_bus_error         <= misaligned;
            o_memwb_instruction <= i_exmem_instruction;
            o_memwb_pc          <= i_exmem_pc;
            o_memwb_alu_result  <= i_exmem_alu_result;
            o_memwb_read_data   <= 64'd0;
            o_memwb_mem_to_reg  <= i_exmem_mem_to_reg;
            o_memwb_reg_write   <= i_exmem_reg_write & ~misaligned;
          end
        end
        ACCESS: begin
          if (i_dmem_ack || timeout_hit) begin
            state               <= IDLE;
            timeout_cnt         <= 16'd0;
            o_stall             <= 1'b0;
            o_dmem_req          <= 1'b0;
            o_bus_error         <= ~i_dmem_ack;
            o_memwb_instruction <= cap_instruction;
            o_memwb_pc          <= cap_pc;
            o_memwb_alu_result  <= cap_alu_result;
            o_memwb_read_data   <= (i_dmem_ack && cap_is_load) ? load_data : 64'd0;
            o_memwb_mem_to_reg  <= cap_mem_to_reg;
            o_memwb_reg_write   <= cap_reg_write & i_dmem_ack;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: table of single-cycle ops plus hand-written
// multi-cycle sequences (load/store handshakes, reset mid-access, timeout, subword).
module tb_memory_access_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_exmem_instruction;
  logic [63:0] i_exmem_pc, i_exmem_rs2_value, i_exmem_alu_result, i_exmem_jmp_addr;
  logic        i_exmem_alu_zero, i_exmem_branch, i_exmem_mem_write, i_exmem_mem_read;
  logic        i_exmem_mem_to_reg, i_exmem_reg_write;
  logic        o_dmem_req, o_dmem_we;
  logic [63:0] o_dmem_addr, o_dmem_wdata;
  logic [7:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [63:0] i_dmem_rdata;
  logic        o_stall, o_pc_src, o_bus_error;
  logic [63:0] o_pc_target;
  logic [31:0] o_memwb_instruction;
  logic [63:0] o_memwb_pc, o_memwb_alu_result, o_memwb_read_data;
  logic        o_memwb_mem_to_reg, o_memwb_reg_write;

  int vec_count  = 0;
  int miss_count = 0;

  memory_access_stage #(.DMEM_ADDR_W(64), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_exmem_instruction(i_exmem_instruction), .i_exmem_pc(i_exmem_pc),
    .i_exmem_rs2_value(i_exmem_rs2_value), .i_exmem_alu_result(i_exmem_alu_result),
    .i_exmem_alu_zero(i_exmem_alu_zero), .i_exmem_jmp_addr(i_exmem_jmp_addr),
    .i_exmem_branch(i_exmem_branch), .i_exmem_mem_write(i_exmem_mem_write),
    .i_exmem_mem_read(i_exmem_mem_read), .i_exmem_mem_to_reg(i_exmem_mem_to_reg),
    .i_exmem_reg_write(i_exmem_reg_write),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_pc_src(o_pc_src), .o_pc_target(o_pc_target),
    .o_bus_error(o_bus_error),
    .o_memwb_instruction(o_memwb_instruction), .o_memwb_pc(o_memwb_pc),
    .o_memwb_alu_result(o_memwb_alu_result), .o_memwb_read_data(o_memwb_read_data),
    .o_memwb_mem_to_reg(o_memwb_mem_to_reg), .o_memwb_reg_write(o_memwb_reg_write)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc, alu, rs2, jmp;
    logic [5:0]  ctl;
  } bundle_t;

  typedef struct {
    bundle_t     in;
    logic        exp_pc_src;
    logic [63:0] exp_target;
    logic        exp_rw;
    logic        exp_m2r;
  } vec_t;

  // ctl = {alu_zero, branch, mem_write, mem_read, mem_to_reg, reg_write}
  function automatic bundle_t mk(input logic [31:0] instr, input logic [63:0] pc, alu, rs2, jmp,
                                 input logic [5:0] ctl);
    bundle_t b;
    b.instr = instr; b.pc = pc; b.alu = alu; b.rs2 = rs2; b.jmp = jmp; b.ctl = ctl;
    return b;
  endfunction

  task automatic applyStimulus(input bundle_t b);
    i_exmem_instruction = b.instr;
    i_exmem_pc          = b.pc;
    i_exmem_alu_result  = b.alu;
    i_exmem_rs2_value   = b.rs2;
    i_exmem_jmp_addr    = b.jmp;
    {i_exmem_alu_zero, i_exmem_branch, i_exmem_mem_write,
     i_exmem_mem_read, i_exmem_mem_to_reg, i_exmem_reg_write} = b.ctl;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  vec_t    vecs [5];
  bundle_t bubble;

  initial begin
    bubble = mk(32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 6'b000000);
    vecs[0] = '{mk(32'h00A00093, 64'h1000, 64'h1234, 64'h0, 64'h0,   6'b000001), 1'b0, 64'h0,   1'b1, 1'b0};
    vecs[1] = '{mk(32'h00208463, 64'h1004, 64'h0,    64'h0, 64'h100, 6'b110000), 1'b1, 64'h100, 1'b0, 1'b0};
    vecs[2] = '{mk(32'h00208463, 64'h1008, 64'h5,    64'h0, 64'h200, 6'b010000), 1'b0, 64'h0,   1'b0, 1'b0};
    vecs[3] = '{mk(32'h00000013, 64'h100C, 64'h0,    64'h0, 64'h0,   6'b000000), 1'b0, 64'h0,   1'b0, 1'b0};
    vecs[4] = '{mk(32'h40208133, 64'h1010, 64'h0,    64'h0, 64'h300, 6'b100001), 1'b0, 64'h0,   1'b1, 1'b0};

    i_rst = 1'b1; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    applyStimulus(mk(32'hFFFFFFFF, 64'h55, 64'h66, 64'h77, 64'h88, 6'b110111));
    tick(); tick();
    checkOutput("reset req",       {63'd0, o_dmem_req},        64'd0);
    checkOutput("reset stall",     {63'd0, o_stall},           64'd0);
    checkOutput("reset pc_src",    {63'd0, o_pc_src},          64'd0);
    checkOutput("reset memwb_pc",  o_memwb_pc,                 64'd0);
    checkOutput("reset memwb_rw",  {63'd0, o_memwb_reg_write}, 64'd0);
    i_rst = 1'b0;

    // Single-cycle (non-memory) ops: MEM/WB and branch outputs follow one edge later.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].in);
      tick();
      checkOutput($sformatf("v%0d pc_src", i), {63'd0, o_pc_src}, {63'd0, vecs[i].exp_pc_src});
      if (vecs[i].exp_pc_src)
        checkOutput($sformatf("v%0d target", i), o_pc_target, vecs[i].exp_target);
      checkOutput($sformatf("v%0d memwb_pc", i),  o_memwb_pc,         vecs[i].in.pc);
      checkOutput($sformatf("v%0d memwb_alu", i), o_memwb_alu_result, vecs[i].in.alu);
      checkOutput($sformatf("v%0d memwb_rw", i),  {63'd0, o_memwb_reg_write},  {63'd0, vecs[i].exp_rw});
      checkOutput($sformatf("v%0d memwb_m2r", i), {63'd0, o_memwb_mem_to_reg}, {63'd0, vecs[i].exp_m2r});
      checkOutput($sformatf("v%0d rdata", i),     o_memwb_read_data,  64'd0);
      checkOutput($sformatf("v%0d stall", i),     {63'd0, o_stall},   64'd0);
      checkOutput($sformatf("v%0d req", i),       {63'd0, o_dmem_req}, 64'd0);
    end

    // LD at 0x40, ack in third ACCESS cycle.
    applyStimulus(mk(32'h0000B083, 64'h2000, 64'h40, 64'h0, 64'h0, 6'b000111));
    tick();
    applyStimulus(bubble);
    checkOutput("ld req",        {63'd0, o_dmem_req}, 64'd1);
    checkOutput("ld we",         {63'd0, o_dmem_we},  64'd0);
    checkOutput("ld addr",       o_dmem_addr,         64'h40);
    checkOutput("ld stall1",     {63'd0, o_stall},    64'd1);
    checkOutput("ld memwb held", o_memwb_pc,          64'h1010);
    tick();
    checkOutput("ld stall2",     {63'd0, o_stall},    64'd1);
    checkOutput("ld addr held",  o_dmem_addr,         64'h40);
    tick();
    checkOutput("ld stall3",     {63'd0, o_stall},    64'd1);
    i_dmem_ack = 1'b1; i_dmem_rdata = 64'h1122334455667788;
    tick();
    i_dmem_ack = 1'b0;
    checkOutput("ld done stall", {63'd0, o_stall},           64'd0);
    checkOutput("ld done req",   {63'd0, o_dmem_req},        64'd0);
    checkOutput("ld rdata",      o_memwb_read_data,          64'h1122334455667788);
    checkOutput("ld rw",         {63'd0, o_memwb_reg_write}, 64'd1);
    checkOutput("ld memwb_pc",   o_memwb_pc,                 64'h2000);

    // SD at 0x18, ack in first ACCESS cycle.
    applyStimulus(mk(32'h0010B023, 64'h2004, 64'h18, 64'hDEADBEEF, 64'h0, 6'b001000));
    tick();
    applyStimulus(bubble);
    checkOutput("sd we",    {63'd0, o_dmem_we},  64'd1);
    checkOutput("sd be",    {56'd0, o_dmem_be},  64'hFF);
    checkOutput("sd wdata", o_dmem_wdata,        64'hDEADBEEF);
    checkOutput("sd addr",  o_dmem_addr,         64'h18);
    checkOutput("sd stall", {63'd0, o_stall},    64'd1);
    i_dmem_ack = 1'b1; i_dmem_rdata = 64'h99;
    tick();
    i_dmem_ack = 1'b0;
    checkOutput("sd done stall", {63'd0, o_stall},           64'd0);
    checkOutput("sd rw",         {63'd0, o_memwb_reg_write}, 64'd0);
    checkOutput("sd rdata",      o_memwb_read_data,          64'd0);

    // Both read and write set: treated as a store.
    applyStimulus(mk(32'h0010B023, 64'h2008, 64'h20, 64'h5A, 64'h0, 6'b001101));
    tick();
    applyStimulus(bubble);
    checkOutput("rw we", {63'd0, o_dmem_we}, 64'd1);
    i_dmem_ack = 1'b1; i_dmem_rdata = 64'h1234;
    tick();
    i_dmem_ack = 1'b0;
    checkOutput("rw rdata", o_memwb_read_data, 64'd0);

    // Reset while an access is outstanding.
    applyStimulus(mk(32'h0000B083, 64'h2100, 64'h48, 64'h0, 64'h0, 6'b000111));
    tick();
    applyStimulus(bubble);
    checkOutput("rst pre req", {63'd0, o_dmem_req}, 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("rst req",      {63'd0, o_dmem_req},        64'd0);
    checkOutput("rst stall",    {63'd0, o_stall},           64'd0);
    checkOutput("rst memwb_pc", o_memwb_pc,                 64'd0);
    checkOutput("rst memwb_in", {32'd0, o_memwb_instruction}, 64'd0);
    checkOutput("rst memwb_rw", {63'd0, o_memwb_reg_write}, 64'd0);
    checkOutput("rst memwb_rd", o_memwb_read_data,          64'd0);
    tick();

    // Timeout after 4 ACCESS cycles without ack.
    applyStimulus(mk(32'h0000B083, 64'h3000, 64'h80, 64'h0, 64'h0, 6'b000111));
    tick();
    applyStimulus(bubble);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("to%0d err", k), {63'd0, o_bus_error}, 64'd0);
      checkOutput($sformatf("to%0d req", k), {63'd0, o_dmem_req},  64'd1);
    end
    tick();
    checkOutput("to err",      {63'd0, o_bus_error},       64'd1);
    checkOutput("to req",      {63'd0, o_dmem_req},        64'd0);
    checkOutput("to stall",    {63'd0, o_stall},           64'd0);
    checkOutput("to rw",       {63'd0, o_memwb_reg_write}, 64'd0);
    checkOutput("to memwb_pc", o_memwb_pc,                 64'h3000);
    tick();
    checkOutput("to err pulse", {63'd0, o_bus_error}, 64'd0);

    // Ack on the fourth ACCESS cycle wins over timeout.
    applyStimulus(mk(32'h0000B083, 64'h3100, 64'h88, 64'h0, 64'h0, 6'b000111));
    tick();
    applyStimulus(bubble);
    tick(); tick(); tick();
    i_dmem_ack = 1'b1; i_dmem_rdata = 64'hCAFE;
    tick();
    i_dmem_ack = 1'b0;
    checkOutput("ack4 err",   {63'd0, o_bus_error},       64'd0);
    checkOutput("ack4 rw",    {63'd0, o_memwb_reg_write}, 64'd1);
    checkOutput("ack4 rdata", o_memwb_read_data,          64'hCAFE);
    checkOutput("ack4 stall", {63'd0, o_stall},           64'd0);

`ifdef MEM_SUBWORD_EN
    // LB at 0x43 with byte 3 = 0x80 sign-extends.
    applyStimulus(mk(32'h00000083, 64'h4000, 64'h43, 64'h0, 64'h0, 6'b000111));
    tick();
    applyStimulus(bubble);
    checkOutput("lb be",   {56'd0, o_dmem_be}, 64'h08);
    checkOutput("lb addr", o_dmem_addr,        64'h40);
    i_dmem_ack = 1'b1; i_dmem_rdata = 64'h00000000_80000000;
    tick();
    i_dmem_ack = 1'b0;
    checkOutput("lb rdata", o_memwb_read_data, 64'hFFFFFFFFFFFFFF80);

    // SH at 0x41 is misaligned: error pulse, no request.
    applyStimulus(mk(32'h00001023, 64'h4004, 64'h41, 64'h1234, 64'h0, 6'b001000));
    tick();
    applyStimulus(bubble);
    checkOutput("sh err",   {63'd0, o_bus_error},       64'd1);
    checkOutput("sh req",   {63'd0, o_dmem_req},        64'd0);
    checkOutput("sh stall", {63'd0, o_stall},           64'd0);
    checkOutput("sh rw",    {63'd0, o_memwb_reg_write}, 64'd0);
    tick();
    checkOutput("sh req2",  {63'd0, o_dmem_req},        64'd0);
    checkOutput("sh err2",  {63'd0, o_bus_error},       64'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
